ts_channel_selector: RTL

Parametrised successor to the QoS main control. Selects one of N_CH MPEG2-TS input channels for the output mux from per-channel signal presence and periodic error counts. Supports a programmable priority list, an error threshold, fallback and manual modes, revert hold-off hysteresis and a switch counter. Sits between the per-channel error counters and the output TS mux, and is programmed over the memory-mapped bus.

---
 rtl/ts_channel_selector.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ts_channel_selector.sv
// Picks one of N_CH TS input channels from signal presence and periodic error
// counts: ranked priority list, fallback, revert hold-off and manual override.
module ts_channel_selector #(
  parameter int N_CH       = 4,
  parameter int ERR_W      = 8,
  parameter int TIMER_W    = 20,
  parameter int SEL_W      = $clog2(N_CH),
  parameter int DEF_TIMER  = 30,
  parameter int DEF_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       valid,
  input  logic [N_CH*ERR_W-1:0] err_count,
  input  logic                  mm_write_en,
  input  logic                  mm_read_en,
  input  logic [7:0]            mm_addr,
  input  logic [31:0]           mm_wdata,
  output logic [31:0]           mm_rdata,
  output logic [SEL_W-1:0]      mux_control,
  output logic                  en_mux,
  output logic                  en_reset_counter
);

  localparam int RANK_W = $clog2(N_CH + 1);
  localparam logic [SEL_W:0] N_CH_L = N_CH[SEL_W:0];

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_REVERT_PEND,
    ST_MANUAL
  } state_t;

  state_t             state, state_nxt;
  logic               fallback_en, manual_en;
  logic [SEL_W-1:0]   manual_ch;
  logic [SEL_W-1:0]   prio [N_CH];
  logic [TIMER_W-1:0] period, timer;
  logic [ERR_W-1:0]   thresh;
  logic [7:0]         holdoff, hold_cnt, hold_cnt_nxt, switch_cnt;
  logic [SEL_W-1:0]   pending, pending_nxt, mux_nxt, cand;
  logic [RANK_W-1:0]  cand_rank, cur_rank, h_rank, v_rank;
  logic [SEL_W-1:0]   h_ch, v_ch;
  logic               h_found, v_found, cur_found, cand_found, eval;
  logic [ERR_W-1:0]   errs [N_CH];
  logic [N_CH-1:0]    healthy;
  logic [31:0]        rdata_nxt;
  logic               wr_status, wr_timer;
  logic               unused_wdata;

  assign unused_wdata = ^mm_wdata;
  assign wr_status    = mm_write_en && (mm_addr == 8'h01);
  assign wr_timer     = mm_write_en && (mm_addr == 8'h03);
  assign eval         = (period != '0) && (timer == period - 1'b1);

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      errs[k]    = err_count[k*ERR_W +: ERR_W];
      healthy[k] = valid[k] && (errs[k] <= thresh);
    end
  end

  // Rank scan: first occurrence of a channel in the list defines its rank.
  always_comb begin
    h_found   = 1'b0;
    v_found   = 1'b0;
    cur_found = 1'b0;
    h_ch      = '0;
    v_ch      = '0;
    h_rank    = '0;
    v_rank    = '0;
    cur_rank  = RANK_W'(N_CH);
    for (int unsigned i = 0; i < N_CH; i++) begin
      if ({1'b0, prio[i]} < N_CH_L) begin
        if (!h_found && healthy[prio[i]]) begin
          h_found = 1'b1;
          h_ch    = prio[i];
          h_rank  = RANK_W'(i);
        end
        if (!v_found && valid[prio[i]]) begin
          v_found = 1'b1;
          v_ch    = prio[i];
          v_rank  = RANK_W'(i);
        end
      end
      if (!cur_found && (prio[i] == mux_control)) begin
        cur_found = 1'b1;
        cur_rank  = RANK_W'(i);
      end
    end
    if (fallback_en) begin
      cand_found = h_found || v_found;
      cand       = h_found ? h_ch : v_ch;
      cand_rank  = h_found ? h_rank : v_rank;
    end else begin
      cand_found = ({1'b0, prio[0]} < N_CH_L);
      cand       = prio[0];
      cand_rank  = '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    mux_nxt      = mux_control;
    pending_nxt  = pending;
    hold_cnt_nxt = hold_cnt;
    if (manual_en) begin
      state_nxt = ST_MANUAL;
      if ({1'b0, manual_ch} < N_CH_L) mux_nxt = manual_ch;
    end else if (eval) begin
      // leaving MANUAL is resolved as a NORMAL evaluation in the same cycle
      if (state == ST_MANUAL) state_nxt = ST_NORMAL;
      if (cand_found) begin
        if (cand_rank >= cur_rank) begin
          state_nxt = ST_NORMAL;
          mux_nxt   = cand;
        end else if ((state == ST_REVERT_PEND) && (cand == pending)) begin
          if ({1'b0, hold_cnt} + 9'd1 >= {1'b0, holdoff}) begin
            state_nxt = ST_NORMAL;
            mux_nxt   = cand;
          end else begin
            hold_cnt_nxt = hold_cnt + 8'd1;
          end
        end else if (holdoff == '0) begin
          state_nxt = ST_NORMAL;
          mux_nxt   = cand;
        end else begin
          state_nxt    = ST_REVERT_PEND;
          pending_nxt  = cand;
          hold_cnt_nxt = 8'd1;
        end
      end
    end
  end

  always_comb begin
    rdata_nxt = '0;
    case (mm_addr)
      8'h00: begin
        rdata_nxt[0]            = fallback_en;
        rdata_nxt[1]            = manual_en;
        rdata_nxt[8 +: SEL_W]   = manual_ch;
      end
      8'h01: begin
        rdata_nxt[SEL_W-1:0]    = mux_control;
        rdata_nxt[8 +: N_CH]    = valid;
        rdata_nxt[16]           = !cand_found;
        rdata_nxt[17]           = (state == ST_REVERT_PEND);
        rdata_nxt[31:24]        = switch_cnt;
      end
      8'h02: begin
        for (int unsigned i = 0; i < N_CH; i++) rdata_nxt[i*4 +: SEL_W] = prio[i];
      end
      8'h03: rdata_nxt[TIMER_W-1:0] = period;
      8'h04: begin
        rdata_nxt[ERR_W-1:0]    = thresh;
        rdata_nxt[23:16]        = holdoff;
      end
      default: begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (mm_addr == 8'(16 + k)) rdata_nxt[ERR_W-1:0] = errs[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fallback_en <= 1'b1;
      manual_en   <= 1'b0;
      manual_ch   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) prio[i] <= SEL_W'(i);
      period      <= TIMER_W'(DEF_TIMER);
      thresh      <= ERR_W'(DEF_THRESH);
      holdoff     <= '0;
    end else if (mm_write_en) begin
      case (mm_addr)
        8'h00: begin
          fallback_en <= mm_wdata[0];
          manual_en   <= mm_wdata[1];
          manual_ch   <= mm_wdata[8 +: SEL_W];
        end
        8'h02: begin
          for (int unsigned i = 0; i < N_CH; i++) prio[i] <= mm_wdata[i*4 +: SEL_W];
        end
        8'h03: period <= mm_wdata[TIMER_W-1:0];
        8'h04: begin
          thresh  <= mm_wdata[ERR_W-1:0];
          holdoff <= mm_wdata[23:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_NORMAL;
      mux_control <= '0;
      pending     <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      mux_control <= mux_nxt;
      pending     <= pending_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer            <= '0;
      en_reset_counter <= 1'b0;
      en_mux           <= 1'b0;
      switch_cnt       <= '0;
      mm_rdata         <= '0;
    end else begin
      if (wr_timer || (period == '0) || eval) timer <= '0;
      else                                    timer <= timer + 1'b1;
      en_reset_counter <= eval;
      en_mux           <= ({1'b0, mux_control} < N_CH_L) && valid[mux_control];
      if (wr_status)                                        switch_cnt <= '0;
      else if ((mux_nxt != mux_control) && (switch_cnt != 8'hFF)) switch_cnt <= switch_cnt + 8'd1;
      if (mm_read_en) mm_rdata <= rdata_nxt;
    end
  end

endmodule
